// File: rtl/dac_spi_arbiter.sv
// dac_spi_arbiter: round-robin arbiter between two word sources feeding the
// serial DAC link. One 24-bit frame (8 control + 16 data bits, MSB first) is
// shifted per grant, followed by a minimum DAC_SYNC high gap.
module dac_spi_arbiter #(
    parameter int CLKDIV     = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_a,
    input  logic [23:0] data_a,
    output logic        ack_a,
    input  logic        req_b,
    input  logic [23:0] data_b,
    output logic        ack_b,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic        dac_sync,
    output logic        dac_sclk,
    output logic        dac_din
);

    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t          state, state_n;
    logic            last_b, last_b_n;
    logic [23:0]     shreg, shreg_n;
    logic [4:0]      bit_cnt, bit_cnt_n;
    logic [DW-1:0]   div_cnt, div_cnt_n;
    logic [GW-1:0]   gap_cnt, gap_cnt_n;
    logic            ack_a_n, ack_b_n, busy_n, done_n, done_id_n;
    logic            sync_n, sclk_n;
    logic            grant_b;

    // The MSB of the shift register drives the pin directly; it is a flop
    // output and is cleared whenever the link is idle.
    assign dac_din = shreg[23];

    // State and output registers; reset puts the link pins in their idle levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            last_b   <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            gap_cnt  <= '0;
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            done_id  <= 1'b0;
            dac_sync <= 1'b1;
            dac_sclk <= 1'b1;
        end else begin
            state    <= state_n;
            last_b   <= last_b_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            div_cnt  <= div_cnt_n;
            gap_cnt  <= gap_cnt_n;
            ack_a    <= ack_a_n;
            ack_b    <= ack_b_n;
            busy     <= busy_n;
            done     <= done_n;
            done_id  <= done_id_n;
            dac_sync <= sync_n;
            dac_sclk <= sclk_n;
        end
    end

    // Next-state logic: grant in IDLE, half-period divider and bit sequencing
    // in SHIFT, fixed high time in GAP.
    always_comb begin
        state_n   = state;
        last_b_n  = last_b;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        div_cnt_n = div_cnt;
        gap_cnt_n = gap_cnt;
        ack_a_n   = 1'b0;
        ack_b_n   = 1'b0;
        busy_n    = busy;
        done_n    = 1'b0;
        done_id_n = done_id;
        sync_n    = dac_sync;
        sclk_n    = dac_sclk;
        grant_b   = 1'b0;

        case (state)
            IDLE: begin
                // B wins when it is the only requester, or on a tie when A was granted last.
                grant_b = req_b && (!req_a || !last_b);
                if (req_a || req_b) begin
                    last_b_n  = grant_b;
                    shreg_n   = grant_b ? data_b : data_a;
                    ack_a_n   = !grant_b;
                    ack_b_n   = grant_b;
                    sync_n    = 1'b0;
                    sclk_n    = 1'b1;
                    busy_n    = 1'b1;
                    bit_cnt_n = '0;
                    div_cnt_n = '0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt == DW'(CLKDIV - 1)) begin
                    div_cnt_n = '0;
                    if (dac_sclk) begin
                        sclk_n = 1'b0;
                    end else if (bit_cnt == 5'd23) begin
                        // Last low half-period finished: close the frame.
                        sclk_n    = 1'b1;
                        sync_n    = 1'b1;
                        shreg_n   = '0;
                        done_n    = 1'b1;
                        done_id_n = last_b;
                        gap_cnt_n = '0;
                        state_n   = GAP;
                    end else begin
                        sclk_n    = 1'b1;
                        bit_cnt_n = bit_cnt + 5'd1;
                        shreg_n   = {shreg[22:0], 1'b0};
                    end
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// tb_dac_spi_arbiter: three DUT instances (CLKDIV/GAP = 2/2, 4/2, 1/1) share
// the requester inputs. A timeline model predicts every output each cycle from
// the elapsed time since the last grant; directed tables and sequences cover
// the frame-level corner cases.
module tb_dac_spi_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req_a, req_b;
    logic [23:0] data_a, data_b;
    logic [2:0]  ack_a_v, ack_b_v, busy_v, done_v, done_id_v, sync_v, sclk_v, din_v;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    dac_spi_arbiter #(.CLKDIV(2), .GAP_CYCLES(2)) u_c2 (
        .clk(clk), .reset_n(rst_n),
        .req_a(req_a), .data_a(data_a), .ack_a(ack_a_v[0]),
        .req_b(req_b), .data_b(data_b), .ack_b(ack_b_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .done_id(done_id_v[0]),
        .dac_sync(sync_v[0]), .dac_sclk(sclk_v[0]), .dac_din(din_v[0])
    );

    dac_spi_arbiter #(.CLKDIV(4), .GAP_CYCLES(2)) u_c4 (
        .clk(clk), .reset_n(rst_n),
        .req_a(req_a), .data_a(data_a), .ack_a(ack_a_v[1]),
        .req_b(req_b), .data_b(data_b), .ack_b(ack_b_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .done_id(done_id_v[1]),
        .dac_sync(sync_v[1]), .dac_sclk(sclk_v[1]), .dac_din(din_v[1])
    );

    dac_spi_arbiter #(.CLKDIV(1), .GAP_CYCLES(1)) u_c1 (
        .clk(clk), .reset_n(rst_n),
        .req_a(req_a), .data_a(data_a), .ack_a(ack_a_v[2]),
        .req_b(req_b), .data_b(data_b), .ack_b(ack_b_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .done_id(done_id_v[2]),
        .dac_sync(sync_v[2]), .dac_sclk(sclk_v[2]), .dac_din(din_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cdiv(input int i);
        case (i)
            0: return 2;
            1: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int gcyc(input int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic bit win_b(input bit ra, input bit rb, input bit lastb);
        return rb && (!ra || !lastb);
    endfunction

    // ---------------- timeline reference model ----------------
    bit          m_act   [3];
    int          m_off   [3];
    bit          m_own   [3];
    bit          m_lastb [3];
    logic [23:0] m_word  [3];

    // Each instance: cycles elapsed since its last grant; a grant is possible
    // once a full frame plus gap has elapsed.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_act[i]   <= 1'b0;
                m_off[i]   <= 0;
                m_own[i]   <= 1'b0;
                m_lastb[i] <= 1'b1;
                m_word[i]  <= '0;
            end else if (!m_act[i] || m_off[i] >= 48 * cdiv(i) + gcyc(i)) begin
                if (req_a || req_b) begin
                    m_act[i]   <= 1'b1;
                    m_off[i]   <= 0;
                    m_own[i]   <= win_b(req_a, req_b, m_lastb[i]);
                    m_lastb[i] <= win_b(req_a, req_b, m_lastb[i]);
                    m_word[i]  <= win_b(req_a, req_b, m_lastb[i]) ? data_b : data_a;
                end
            end else begin
                m_off[i] <= m_off[i] + 1;
            end
        end
    end

    // {sync, sclk, din, ack_a, ack_b, busy, done, done_id-while-done}
    function automatic logic [7:0] exp_vec(input int i);
        int c, f, off;
        logic [7:0] e;
        if (!m_act[i]) return 8'b1100_0000;
        c   = cdiv(i);
        f   = 48 * c;
        off = m_off[i];
        e[7] = (off >= f);
        e[6] = (off >= f) ? 1'b1 : ((off % (2 * c)) < c);
        e[5] = (off < f) ? m_word[i][23 - off / (2 * c)] : 1'b0;
        e[4] = (off == 0) && !m_own[i];
        e[3] = (off == 0) && m_own[i];
        e[2] = (off < f + gcyc(i));
        e[1] = (off == f);
        e[0] = (off == f) && m_own[i];
        return e;
    endfunction

    function automatic logic [7:0] act_vec(input int i);
        return {sync_v[i], sclk_v[i], din_v[i], ack_a_v[i], ack_b_v[i],
                busy_v[i], done_v[i], done_v[i] & done_id_v[i]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("model_u%0d", i), 32'(act_vec(i)), 32'(exp_vec(i)));
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Follows one frame on instance i: high cycles before it, low length,
    // word sampled at falling SCLK, acks seen, done/done_id at the SYNC rise.
    task automatic measure_frame(input int i, output logic [23:0] w, output int low,
                                 output int hi, output int acks, output bit id,
                                 output bit dn, output bit to);
        int n;
        bit prev, fin;
        w = '0; low = 0; hi = 0; acks = 0; id = 1'b0; dn = 1'b0; to = 1'b1;
        n = 0; prev = 1'b1; fin = 1'b0;
        while (!fin && n < 2000) begin
            @(negedge clk);
            n++;
            if (ack_a_v[i] || ack_b_v[i]) acks++;
            if (!sync_v[i]) begin
                low++;
                if (prev && !sclk_v[i]) w = {w[22:0], din_v[i]};
                prev = sclk_v[i];
            end else if (low > 0) begin
                dn  = done_v[i];
                id  = done_id_v[i];
                to  = 1'b0;
                fin = 1'b1;
            end else begin
                hi++;
            end
        end
    endtask

    task automatic wait_ack(input int i, input bit b, output bit to);
        int n;
        n = 0;
        to = 1'b1;
        while (to && n < 500) begin
            @(negedge clk);
            n++;
            if (b ? ack_b_v[i] : ack_a_v[i]) to = 1'b0;
        end
    endtask

    task automatic watch(input int i, input int cyc, inout int nb, inout int nf);
        bit prev;
        prev = sync_v[i];
        for (int k = 0; k < cyc; k++) begin
            @(negedge clk);
            if (ack_b_v[i]) nb++;
            if (prev && !sync_v[i]) nf++;
            prev = sync_v[i];
        end
    endtask

    typedef struct {
        bit          ra;
        bit          rb;
        logic [23:0] da;
        logic [23:0] db;
        bit          exp_id;
        logic [23:0] exp_word;
    } vec_t;

    vec_t        tbl [5];
    logic [23:0] w;
    int          low, hi, acks, t, nb, nf, got;
    bit          id, dn, to;
    int          t_ack [4];
    bit          id_ack [4];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 24'h00ABCD, 24'h000000, 1'b0, 24'h00ABCD};
        tbl[1] = '{1'b0, 1'b1, 24'h111111, 24'h5A5AA5, 1'b1, 24'h5A5AA5};
        tbl[2] = '{1'b1, 1'b1, 24'h000001, 24'h000002, 1'b0, 24'h000001};
        tbl[3] = '{1'b1, 1'b0, 24'hFFFFFF, 24'h000000, 1'b0, 24'hFFFFFF};
        tbl[4] = '{1'b0, 1'b1, 24'h000000, 24'h800001, 1'b1, 24'h800001};

        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0;
        repeat (2) @(negedge clk);
        chk("reset_sync", 32'(sync_v), 32'h7);
        chk("reset_sclk", 32'(sclk_v), 32'h7);
        chk("reset_din", 32'(din_v), 32'h0);
        chk("reset_flags", 32'({ack_a_v, ack_b_v, busy_v, done_v, done_id_v}), 32'h0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // Single frames from idle on the CLKDIV=2 instance.
        for (int k = 0; k < 5; k++) begin
            do_reset();
            data_a = tbl[k].da; data_b = tbl[k].db;
            req_a  = tbl[k].ra; req_b  = tbl[k].rb;
            measure_frame(0, w, low, hi, acks, id, dn, to);
            req_a = 1'b0; req_b = 1'b0;
            chk($sformatf("tbl%0d_timeout", k), 32'(to), 32'h0);
            chk($sformatf("tbl%0d_word", k), 32'(w), 32'(tbl[k].exp_word));
            chk($sformatf("tbl%0d_sync_low", k), 32'(low), 32'd96);
            chk($sformatf("tbl%0d_ack_cycles", k), 32'(acks), 32'd1);
            chk($sformatf("tbl%0d_done", k), 32'(dn), 32'h1);
            chk($sformatf("tbl%0d_done_id", k), 32'(id), 32'(tbl[k].exp_id));
            t = 0;
            while (busy_v[0] && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("tbl%0d_busy_tail", k), 32'(t), 32'd2);
        end

        // Tie after reset: A then B, gap of three SYNC-high cycles.
        do_reset();
        data_a = 24'h000001; data_b = 24'h000002; req_a = 1'b1; req_b = 1'b1;
        measure_frame(0, w, low, hi, acks, id, dn, to);
        chk("tie_f1_timeout", 32'(to), 32'h0);
        chk("tie_f1_id", 32'(id), 32'h0);
        chk("tie_f1_word", 32'(w), 32'h000001);
        measure_frame(0, w, low, hi, acks, id, dn, to);
        req_a = 1'b0; req_b = 1'b0;
        chk("tie_f2_timeout", 32'(to), 32'h0);
        chk("tie_gap_high", 32'(hi + 1), 32'd3);
        chk("tie_f2_id", 32'(id), 32'h1);
        chk("tie_f2_word", 32'(w), 32'h000002);
        chk("tie_f2_ack", 32'(acks), 32'd1);

        // Both held: grants alternate on the default-parameter instance.
        do_reset();
        data_a = 24'h111111; data_b = 24'h222222; req_a = 1'b1; req_b = 1'b1;
        got = 0; t = 0;
        while (got < 4 && t < 1000) begin
            @(negedge clk);
            t++;
            if (ack_a_v[1] || ack_b_v[1]) begin
                t_ack[got]  = t;
                id_ack[got] = ack_b_v[1];
                got++;
            end
        end
        chk("alt_grants", 32'(got), 32'd4);
        for (int j = 0; j < got; j++)
            chk($sformatf("alt_owner%0d", j), 32'(id_ack[j]), 32'(j % 2));
        for (int j = 1; j < got; j++)
            chk($sformatf("alt_period%0d", j), 32'(t_ack[j] - t_ack[j-1]), 32'd195);

        // Reset during bit 10, with B pending.
        do_reset();
        data_a = 24'h0F0F0F; req_a = 1'b1;
        wait_ack(0, 1'b0, to);
        chk("rst_ack_timeout", 32'(to), 32'h0);
        req_a = 1'b0; data_b = 24'h3C3C3C; req_b = 1'b1;
        repeat (41) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_sync", 32'(sync_v), 32'h7);
        chk("rst_async_sclk", 32'(sclk_v), 32'h7);
        chk("rst_async_din", 32'(din_v), 32'h0);
        chk("rst_async_done", 32'(done_v), 32'h0);
        @(negedge clk);
        chk("rst_hold_done", 32'(done_v), 32'h0);
        rst_n = 1'b1;
        measure_frame(0, w, low, hi, acks, id, dn, to);
        req_b = 1'b0;
        chk("rst_after_timeout", 32'(to), 32'h0);
        chk("rst_after_id", 32'(id), 32'h1);
        chk("rst_after_word", 32'(w), 32'h3C3C3C);
        chk("rst_after_ack", 32'(acks), 32'd1);

        // req_b withdrawn before the gap ends is never served.
        do_reset();
        data_a = 24'hA5A5A5; req_a = 1'b1;
        wait_ack(0, 1'b0, to);
        chk("drop_ack_timeout", 32'(to), 32'h0);
        req_a = 1'b0;
        nb = 0; nf = 0;
        watch(0, 20, nb, nf);
        data_b = 24'h123456; req_b = 1'b1;
        watch(0, 60, nb, nf);
        req_b = 1'b0;
        watch(0, 150, nb, nf);
        chk("drop_no_ack_b", 32'(nb), 32'd0);
        chk("drop_no_frame", 32'(nf), 32'd0);

        // Random requesters; data only changes while its req is low.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (req_a) begin
                if ($urandom_range(7) == 0) req_a = 1'b0;
            end else if ($urandom_range(5) == 0) begin
                data_a = 24'($urandom);
                req_a  = 1'b1;
            end
            if (req_b) begin
                if ($urandom_range(7) == 0) req_b = 1'b0;
            end else if ($urandom_range(5) == 0) begin
                data_b = 24'($urandom);
                req_b  = 1'b1;
            end
            if ($urandom_range(999) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
